// File: rtl/seven_seg_demux_decoder.sv
// Receive side of a time-multiplexed two-digit 7-segment bus: syncs and settles the bus,
// rebuilds {hi,lo}, decodes to hex, flags illegal/stale data. SEVEN_SEG_ERRCNT_EN adds err_count.
module seven_seg_demux_decoder #(
  parameter int SETTLE  = 4,
  parameter int TIMEOUT = 8192
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [6:0]  seg_in,
  input  logic        dsel_in,
  output logic [13:0] both7seg_out,
  output logic [3:0]  digit_hi,
  output logic [3:0]  digit_lo,
  output logic        hi_valid,
  output logic        lo_valid,
  output logic        frame_done,
  output logic        err_pulse,
  output logic        stale
`ifdef SEVEN_SEG_ERRCNT_EN
  ,
  output logic [7:0]  err_count
`endif
);

  localparam int CNT_W  = $clog2(SETTLE + 1);
  localparam int TCNT_W = $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0]  SETTLE_C = CNT_W'(SETTLE);
  localparam logic [CNT_W-1:0]  CAP_AT   = CNT_W'(SETTLE - 1);
  localparam logic [TCNT_W-1:0] TMAX     = TCNT_W'(TIMEOUT - 1);
  localparam logic [TCNT_W-1:0] TSTALE   = TCNT_W'(TIMEOUT - 2);

  // Returns {legal, hex}; unknown patterns decode to {0, 0}.
  function automatic logic [4:0] decode(input logic [6:0] p);
    case (p)
      7'h3F: decode = 5'h10;
      7'h06: decode = 5'h11;
      7'h5B: decode = 5'h12;
      7'h4F: decode = 5'h13;
      7'h66: decode = 5'h14;
      7'h6D: decode = 5'h15;
      7'h7D: decode = 5'h16;
      7'h07: decode = 5'h17;
      7'h7F: decode = 5'h18;
      7'h6F: decode = 5'h19;
      7'h77: decode = 5'h1A;
      7'h7C: decode = 5'h1B;
      7'h39: decode = 5'h1C;
      7'h5E: decode = 5'h1D;
      7'h79: decode = 5'h1E;
      7'h71: decode = 5'h1F;
      default: decode = 5'h00;
    endcase
  endfunction

  logic [7:0]        s1_q, s1_d, s2_q, s2_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [TCNT_W-1:0] tcnt_q, tcnt_d;
  logic [6:0]        hi_seg_q, hi_seg_d, lo_seg_q, lo_seg_d;
  logic [3:0]        dig_hi_q, dig_hi_d, dig_lo_q, dig_lo_d;
  logic              hi_vld_q, hi_vld_d, lo_vld_q, lo_vld_d;
  logic              last_hi_q, last_hi_d;
  logic              fd_q, fd_d, err_q, err_d, stale_q, stale_d;
  logic              same, capture;
  logic [4:0]        dec;

  always_comb begin
    s1_d      = {dsel_in, seg_in};
    s2_d      = s1_q;
    same      = (s1_q == s2_q);
    capture   = same && (cnt_q == CAP_AT);
    dec       = decode(s2_q[6:0]);
    cnt_d     = cnt_q;
    tcnt_d    = tcnt_q;
    hi_seg_d  = hi_seg_q;
    lo_seg_d  = lo_seg_q;
    dig_hi_d  = dig_hi_q;
    dig_lo_d  = dig_lo_q;
    hi_vld_d  = hi_vld_q;
    lo_vld_d  = lo_vld_q;
    last_hi_d = last_hi_q;
    stale_d   = stale_q;
    fd_d      = 1'b0;
    err_d     = 1'b0;

    // Settle counter parks at SETTLE so a stable period captures only once.
    if (!same) begin
      cnt_d = '0;
    end else if (cnt_q != SETTLE_C) begin
      cnt_d = cnt_q + 1'b1;
    end

    if (capture) begin
      tcnt_d    = '0;
      stale_d   = 1'b0;
      err_d     = ~dec[4];
      last_hi_d = s2_q[7];
      if (s2_q[7]) begin
        hi_seg_d = s2_q[6:0];
        dig_hi_d = dec[3:0];
        hi_vld_d = 1'b1;
      end else begin
        lo_seg_d = s2_q[6:0];
        dig_lo_d = dec[3:0];
        lo_vld_d = 1'b1;
        fd_d     = last_hi_q;
      end
    end else begin
      if (tcnt_q != TMAX) begin
        tcnt_d = tcnt_q + 1'b1;
      end
      // Display data is kept; only the validity flags drop when stale.
      if (tcnt_q >= TSTALE) begin
        stale_d  = 1'b1;
        hi_vld_d = 1'b0;
        lo_vld_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q      <= '0;
      s2_q      <= '0;
      cnt_q     <= '0;
      tcnt_q    <= '0;
      hi_seg_q  <= '0;
      lo_seg_q  <= '0;
      dig_hi_q  <= '0;
      dig_lo_q  <= '0;
      hi_vld_q  <= 1'b0;
      lo_vld_q  <= 1'b0;
      last_hi_q <= 1'b0;
      fd_q      <= 1'b0;
      err_q     <= 1'b0;
      stale_q   <= 1'b0;
    end else begin
      s1_q      <= s1_d;
      s2_q      <= s2_d;
      cnt_q     <= cnt_d;
      tcnt_q    <= tcnt_d;
      hi_seg_q  <= hi_seg_d;
      lo_seg_q  <= lo_seg_d;
      dig_hi_q  <= dig_hi_d;
      dig_lo_q  <= dig_lo_d;
      hi_vld_q  <= hi_vld_d;
      lo_vld_q  <= lo_vld_d;
      last_hi_q <= last_hi_d;
      fd_q      <= fd_d;
      err_q     <= err_d;
      stale_q   <= stale_d;
    end
  end

`ifdef SEVEN_SEG_ERRCNT_EN
  logic [7:0] errcnt_q, errcnt_d;

  always_comb begin
    errcnt_d = errcnt_q;
    if (err_d && (errcnt_q != 8'hFF)) begin
      errcnt_d = errcnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      errcnt_q <= '0;
    end else begin
      errcnt_q <= errcnt_d;
    end
  end

  assign err_count = errcnt_q;
`endif

  assign both7seg_out = {hi_seg_q, lo_seg_q};
  assign digit_hi     = dig_hi_q;
  assign digit_lo     = dig_lo_q;
  assign hi_valid     = hi_vld_q;
  assign lo_valid     = lo_vld_q;
  assign frame_done   = fd_q;
  assign err_pulse    = err_q;
  assign stale        = stale_q;

endmodule

// File: tb/tb_seven_seg_demux_decoder.sv
// Directed bench for seven_seg_demux_decoder (SETTLE=4, TIMEOUT=8192); inputs change 1 time
// unit after a rising edge, outputs are sampled at the same point.
module tb_seven_seg_demux_decoder;

  logic        clk = 1'b0;
  logic        rst;
  logic [6:0]  seg_in;
  logic        dsel_in;
  logic [13:0] both7seg_out;
  logic [3:0]  digit_hi, digit_lo;
  logic        hi_valid, lo_valid, frame_done, err_pulse, stale;
`ifdef SEVEN_SEG_ERRCNT_EN
  logic [7:0]  err_count;
`endif

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  seven_seg_demux_decoder #(.SETTLE(4), .TIMEOUT(8192)) dut (
    .clk          (clk),
    .rst          (rst),
    .seg_in       (seg_in),
    .dsel_in      (dsel_in),
    .both7seg_out (both7seg_out),
    .digit_hi     (digit_hi),
    .digit_lo     (digit_lo),
    .hi_valid     (hi_valid),
    .lo_valid     (lo_valid),
    .frame_done   (frame_done),
    .err_pulse    (err_pulse),
    .stale        (stale)
`ifdef SEVEN_SEG_ERRCNT_EN
    ,
    .err_count    (err_count)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reset with hi=06 already on the bus; everything must read 0 after the reset edge.
  task automatic test_reset();
    dsel_in = 1'b1;
    seg_in  = 7'h06;
    rst     = 1'b1;
    tick();
    tick();
    n_vec++;
    if ({both7seg_out, digit_hi, digit_lo, hi_valid, lo_valid, frame_done, err_pulse, stale} !== 27'd0) begin
      n_bad++;
      $display("FAIL reset_outputs: got both=%h hi=%h lo=%h hv=%b lv=%b fd=%b ep=%b st=%b, want all 0",
               both7seg_out, digit_hi, digit_lo, hi_valid, lo_valid, frame_done, err_pulse, stale);
    end
`ifdef SEVEN_SEG_ERRCNT_EN
    n_vec++;
    if (err_count !== 8'd0) begin
      n_bad++;
      $display("FAIL reset_err_count: got %0d want 0", err_count);
    end
`endif
    rst = 1'b0;
  endtask

  // Hi 06 is already driven; 10 cycles then lo 5B for 10 cycles.
  task automatic test_frame();
    int fd_seen = 0;
    for (int i = 1; i <= 10; i++) begin
      tick();
      if (frame_done) fd_seen++;
    end
    dsel_in = 1'b0;
    seg_in  = 7'h5B;
    for (int i = 1; i <= 10; i++) begin
      tick();
      n_vec++;
      if (frame_done !== (i == 6)) begin
        n_bad++;
        $display("FAIL frame_done_timing: tick %0d got %b want %b", i, frame_done, (i == 6));
      end
      if (frame_done) fd_seen++;
    end
    n_vec++;
    if (fd_seen != 1) begin
      n_bad++;
      $display("FAIL frame_done_count: got %0d want 1", fd_seen);
    end
    n_vec++;
    if (both7seg_out !== 14'h035B || digit_hi !== 4'd1 || digit_lo !== 4'd2 ||
        hi_valid !== 1'b1 || lo_valid !== 1'b1 || err_pulse !== 1'b0 || stale !== 1'b0) begin
      n_bad++;
      $display("FAIL frame_values: got both=%h hi=%h lo=%h hv=%b lv=%b st=%b, want 035B 1 2 1 1 0",
               both7seg_out, digit_hi, digit_lo, hi_valid, lo_valid, stale);
    end
  endtask

  // Lo capture was 4 edges ago; stale must rise exactly 8191 edges after it.
  task automatic test_timeout();
    for (int i = 0; i < 8186; i++) tick();
    n_vec++;
    if (stale !== 1'b0 || hi_valid !== 1'b1 || lo_valid !== 1'b1) begin
      n_bad++;
      $display("FAIL timeout_early: got st=%b hv=%b lv=%b want 0 1 1", stale, hi_valid, lo_valid);
    end
    tick();
    n_vec++;
    if (stale !== 1'b1 || hi_valid !== 1'b0 || lo_valid !== 1'b0 ||
        both7seg_out !== 14'h035B || digit_hi !== 4'd1 || digit_lo !== 4'd2) begin
      n_bad++;
      $display("FAIL timeout_stale: got st=%b hv=%b lv=%b both=%h hi=%h lo=%h want 1 0 0 035B 1 2",
               stale, hi_valid, lo_valid, both7seg_out, digit_hi, digit_lo);
    end
    dsel_in = 1'b1;
    seg_in  = 7'h06;
    for (int i = 0; i < 5; i++) tick();
    n_vec++;
    if (stale !== 1'b1) begin
      n_bad++;
      $display("FAIL timeout_hold: got st=%b want 1", stale);
    end
    tick();
    n_vec++;
    if (stale !== 1'b0 || hi_valid !== 1'b1 || lo_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL timeout_recover: got st=%b hv=%b lv=%b want 0 1 0", stale, hi_valid, lo_valid);
    end
    for (int i = 0; i < 4; i++) tick();
  endtask

  task automatic test_latency();
    seg_in = 7'h4F;
    for (int i = 0; i < 5; i++) tick();
    n_vec++;
    if (digit_hi !== 4'd1) begin
      n_bad++;
      $display("FAIL latency_early: got digit_hi=%h want 1", digit_hi);
    end
    tick();
    n_vec++;
    if (digit_hi !== 4'd3 || both7seg_out !== 14'h27DB) begin
      n_bad++;
      $display("FAIL latency_capture: got digit_hi=%h both=%h want 3 27DB", digit_hi, both7seg_out);
    end
    seg_in = 7'h06;
    for (int i = 0; i < 10; i++) tick();
  endtask

  task automatic test_glitch();
    int pulses = 0;
    int wrong  = 0;
    seg_in = 7'h7F;
    tick();
    tick();
    seg_in = 7'h06;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (frame_done || err_pulse) pulses++;
      if (digit_hi !== 4'd1) wrong++;
    end
    n_vec++;
    if (pulses != 0 || wrong != 0 || both7seg_out[13:7] !== 7'h06) begin
      n_bad++;
      $display("FAIL glitch_reject: pulses=%0d bad_digit_ticks=%0d hi_seg=%h want 0 0 06",
               pulses, wrong, both7seg_out[13:7]);
    end
  endtask

  task automatic test_illegal();
    int errs = 0;
    seg_in = 7'h00;
    for (int i = 1; i <= 10; i++) begin
      tick();
      n_vec++;
      if (err_pulse !== (i == 6)) begin
        n_bad++;
        $display("FAIL illegal_pulse: tick %0d got %b want %b", i, err_pulse, (i == 6));
      end
    end
    n_vec++;
    if (digit_hi !== 4'd0 || hi_valid !== 1'b1 || both7seg_out !== 14'h005B) begin
      n_bad++;
      $display("FAIL illegal_values: got digit_hi=%h hv=%b both=%h want 0 1 005B",
               digit_hi, hi_valid, both7seg_out);
    end
`ifdef SEVEN_SEG_ERRCNT_EN
    n_vec++;
    if (err_count !== 8'd1) begin
      n_bad++;
      $display("FAIL err_count_one: got %0d want 1", err_count);
    end
`endif
    for (int i = 0; i < 300; i++) begin
      seg_in = (i % 2 == 0) ? 7'h01 : 7'h00;
      for (int j = 0; j < 6; j++) begin
        tick();
        if (err_pulse) errs++;
      end
    end
    n_vec++;
    if (errs != 300) begin
      n_bad++;
      $display("FAIL illegal_run: got %0d err pulses want 300", errs);
    end
`ifdef SEVEN_SEG_ERRCNT_EN
    n_vec++;
    if (err_count !== 8'd255) begin
      n_bad++;
      $display("FAIL err_count_sat: got %0d want 255", err_count);
    end
`endif
  endtask

  task automatic test_reset_mid_frame();
    int fd_seen = 0;
    seg_in = 7'h66;
    for (int i = 0; i < 6; i++) tick();
    n_vec++;
    if (digit_hi !== 4'd4) begin
      n_bad++;
      $display("FAIL midrst_hi_capture: got digit_hi=%h want 4", digit_hi);
    end
    rst = 1'b1;
    tick();
    rst     = 1'b0;
    dsel_in = 1'b0;
    seg_in  = 7'h6D;
    n_vec++;
    if ({both7seg_out, digit_hi, digit_lo, hi_valid, lo_valid, frame_done, err_pulse, stale} !== 27'd0) begin
      n_bad++;
      $display("FAIL midrst_cleared: got both=%h hi=%h lo=%h hv=%b lv=%b, want all 0",
               both7seg_out, digit_hi, digit_lo, hi_valid, lo_valid);
    end
    for (int i = 0; i < 10; i++) begin
      tick();
      if (frame_done) fd_seen++;
    end
    n_vec++;
    if (fd_seen != 0 || lo_valid !== 1'b1 || hi_valid !== 1'b0 ||
        digit_lo !== 4'd5 || both7seg_out !== 14'h006D) begin
      n_bad++;
      $display("FAIL midrst_lo: fd=%0d lv=%b hv=%b lo=%h both=%h want 0 1 0 5 006D",
               fd_seen, lo_valid, hi_valid, digit_lo, both7seg_out);
    end
  endtask

  initial begin
    rst     = 1'b1;
    dsel_in = 1'b0;
    seg_in  = 7'h00;
    test_reset();
    test_frame();
    test_timeout();
    test_latency();
    test_glitch();
    test_illegal();
    test_reset_mid_frame();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
